// File: rtl/i2s_frame_serializer.sv
// I2S frame serializer: takes signed stereo sample pairs over a valid/ready
// handshake and shifts them out MSB-first in 32-bit slots, generating
// BCLK (clk/4) and LRCLK (clk/256) from the 256x-fs master clock.
// A one-deep holding register decouples source timing from the frame;
// underrun and overrun events are counted in saturating debug counters.
module i2s_frame_serializer #(
  parameter int SAMPLE_BITS = 16,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [SAMPLE_BITS-1:0] sample_l,
  input  logic signed [SAMPLE_BITS-1:0] sample_r,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic                          frame_start,
  output logic [CNT_W-1:0]              underrun_cnt,
  output logic [CNT_W-1:0]              overrun_cnt
);

  localparam logic [5:0] SB6 = 6'(SAMPLE_BITS);

  logic [7:0]             cnt;
  logic [7:0]             cnt_nxt;
  logic                   load;
  logic [5:0]             pos;
  logic [4:0]             slot;
  logic [5:0]             bit_idx;
  logic [SAMPLE_BITS-1:0] word;
  logic [SAMPLE_BITS-1:0] shifted;
  logic                   sdata_nxt;

  logic [SAMPLE_BITS-1:0] hold_l;
  logic [SAMPLE_BITS-1:0] hold_r;
  logic [SAMPLE_BITS-1:0] act_l;
  logic [SAMPLE_BITS-1:0] act_r;
  logic                   armed;

  // All outputs are derived from the value cnt takes on this edge.
  assign cnt_nxt = cnt + 8'd1;
  assign load    = (cnt == 8'hFF);
  assign pos     = cnt_nxt[7:2];
  assign slot    = pos[4:0];

  // Select the active-channel bit for the upcoming bit slot (one-BCLK I2S delay).
  always_comb begin
    sdata_nxt = 1'b0;
    bit_idx   = '0;
    shifted   = '0;
    word      = pos[5] ? act_r : act_l;
    if (slot != 5'd0 && {1'b0, slot} <= SB6) begin
      bit_idx   = SB6 - {1'b0, slot};
      shifted   = word >> bit_idx;
      sdata_nxt = shifted[0];
    end
  end

  // Frame timing counter and registered I2S outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      bclk        <= cnt_nxt[1];
      lrclk       <= cnt_nxt[7];
      sdata       <= sdata_nxt;
      frame_start <= (cnt_nxt == 8'd0);
    end
  end

  // Handshake, holding register, frame load and saturating debug counters.
  // sample_ready doubles as the "holding empty" flag. On a load edge a
  // full holding register is freed, so an offer in that same cycle is
  // accepted even though ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_ready <= 1'b1;
      hold_l       <= '0;
      hold_r       <= '0;
      act_l        <= '0;
      act_r        <= '0;
      armed        <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else if (load) begin
      if (!sample_ready) begin
        act_l <= hold_l;
        act_r <= hold_r;
        if (sample_valid) begin
          hold_l <= sample_l;
          hold_r <= sample_r;
          armed  <= 1'b1;
        end else begin
          sample_ready <= 1'b1;
        end
      end else if (sample_valid) begin
        act_l <= sample_l;
        act_r <= sample_r;
        armed <= 1'b1;
      end else if (armed && underrun_cnt != '1) begin
        underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
    end else if (sample_valid) begin
      if (sample_ready) begin
        hold_l       <= sample_l;
        hold_r       <= sample_r;
        sample_ready <= 1'b0;
        armed        <= 1'b1;
      end else if (overrun_cnt != '1) begin
        overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Scoreboard bench for i2s_frame_serializer. A transaction-level model
// (holding queue, active pair, integer counters) predicts each frame's
// pair and counters at the load; a monitor pops the prediction on every
// frame_start and checks the serial stream bit by bit against it.
module tb_i2s_frame_serializer;

  localparam int SB   = 16;
  localparam int CW   = 5;
  localparam int SATI = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [SB-1:0] sample_l;
  logic signed [SB-1:0] sample_r;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 bclk;
  logic                 lrclk;
  logic                 sdata;
  logic                 frame_start;
  logic [CW-1:0]        underrun_cnt;
  logic [CW-1:0]        overrun_cnt;

  i2s_frame_serializer #(.SAMPLE_BITS(SB), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SB-1:0] l;
    logic [SB-1:0] r;
    int            under;
    int            over;
  } frame_t;

  int checks = 0;
  int errors = 0;

  frame_t        exp_q[$];
  logic [SB-1:0] hq_l[$];
  logic [SB-1:0] hq_r[$];
  logic [SB-1:0] m_act_l;
  logic [SB-1:0] m_act_r;
  bit            m_armed;
  int            m_under;
  int            m_over;
  int            edges;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Clock edges since reset release; edge n leaves the DUT frame counter at n mod 256.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  // Monitor: checks I2S waveform every cycle, pops a frame prediction at each frame_start.
  logic [SB-1:0] cur_l = '0;
  logic [SB-1:0] cur_r = '0;
  logic [SB-1:0] w;
  int            c;
  int            p;
  int            s;
  logic          exp_sd;
  frame_t        f;

  always @(negedge clk) begin
    if (rst) begin
      cur_l = '0;
      cur_r = '0;
      check("rst_bclk", bclk, 0);
      check("rst_lrclk", lrclk, 0);
      check("rst_sdata", sdata, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_ready", sample_ready, 1);
      check("rst_underrun", underrun_cnt, 0);
      check("rst_overrun", overrun_cnt, 0);
    end else begin
      c = edges % 256;
      if (frame_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("frame_unexpected", 1, 0);
        end else begin
          f = exp_q.pop_front();
          cur_l = f.l;
          cur_r = f.r;
          check("frame_underrun", underrun_cnt, f.under);
          check("frame_overrun", overrun_cnt, f.over);
        end
      end
      p = c / 4;
      s = p % 32;
      w = (p >= 32) ? cur_r : cur_l;
      exp_sd = (s >= 1 && s <= SB) ? w[SB - s] : 1'b0;
      check("bclk", bclk, (c / 2) % 2);
      check("lrclk", lrclk, c / 128);
      check("frame_start", frame_start, (c == 0 && edges != 0));
      check("sdata", sdata, exp_sd);
    end
  end

  // One clock of stimulus; called at posedge+1. Predicts the effect of the coming edge.
  task automatic step(input bit v, input logic [SB-1:0] l, input logic [SB-1:0] r);
    bit is_load;
    check("sample_ready", sample_ready, hq_l.size() == 0);
    check("underrun_cnt", underrun_cnt, m_under);
    check("overrun_cnt", overrun_cnt, m_over);
    sample_valid = v;
    sample_l     = l;
    sample_r     = r;
    is_load = ((edges + 1) % 256 == 0);
    if (is_load) begin
      if (hq_l.size() != 0) begin
        m_act_l = hq_l.pop_front();
        m_act_r = hq_r.pop_front();
        if (v) begin
          hq_l.push_back(l);
          hq_r.push_back(r);
          m_armed = 1;
        end
      end else if (v) begin
        m_act_l = l;
        m_act_r = r;
        m_armed = 1;
      end else if (m_armed) begin
        m_under = (m_under < SATI) ? m_under + 1 : SATI;
      end
      exp_q.push_back('{m_act_l, m_act_r, m_under, m_over});
    end else if (v) begin
      if (hq_l.size() == 0) begin
        hq_l.push_back(l);
        hq_r.push_back(r);
        m_armed = 1;
      end else begin
        m_over = (m_over < SATI) ? m_over + 1 : SATI;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, SB'($urandom), SB'($urandom));
  endtask

  task automatic wait_to_load();
    while ((edges + 1) % 256 != 0) idle(1);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    sample_valid = 1'b0;
    #1;
    check("async_bclk", bclk, 0);
    check("async_lrclk", lrclk, 0);
    check("async_sdata", sdata, 0);
    check("async_ready", sample_ready, 1);
    check("async_underrun", underrun_cnt, 0);
    exp_q.delete();
    hq_l.delete();
    hq_r.delete();
    m_act_l = '0;
    m_act_r = '0;
    m_armed = 0;
    m_under = 0;
    m_over  = 0;
    repeat (cyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    rst          = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Idle after reset: silent frames, no underrun.
    idle(600);

    // Single known pair offered mid-frame, then starvation until saturation.
    while (edges % 256 != 9) idle(1);
    step(1, 16'h8001, 16'h7FFE);
    idle(256 * 34);

    // Continuous offers with changing data.
    repeat (700) step(1, SB'($urandom), SB'($urandom));

    // Offer exactly on the load edge with holding empty (bypass).
    idle(300);
    wait_to_load();
    step(1, 16'hA5C3, 16'h3C5A);
    idle(100);
    // Same, with holding already full.
    step(1, 16'h1234, 16'hFEDC);
    wait_to_load();
    step(1, 16'h0F0F, 16'hF0F0);
    idle(600);

    // Asynchronous reset mid-frame at cnt=130.
    while (edges % 256 != 130) idle(1);
    do_reset(3);
    idle(300);

    // Random mix: sparse then dense offers.
    repeat (2000) step($urandom_range(0, 99) < 3, SB'($urandom), SB'($urandom));
    repeat (1000) step($urandom_range(0, 99) < 60, SB'($urandom), SB'($urandom));
    idle(300);

    @(negedge clk);
    #1;
    check("frames_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
